fp_add_normalizer: RTL and testbench
====================================

Name: fp_add_normalizer

Overview:
- Post-adder normalization stage of the floating-point adder datapath.
- Consumes the 17-bit magnitude result (carry + 16-bit mantissa) of the mantissa add/subtract stage, plus the tentative exponent and sign.
- Produces a normalized mantissa (MSB = 1), adjusted exponent, sign, and zero/overflow/underflow flags.
- Left normalization is iterative (one bit per cycle); valid/ready handshakes on both sides.

Parameters:
- MANT_W, 16, mantissa width; input sum is MANT_W+1 bits.
- EXP_W, 8, exponent width; all-ones exponent = overflow code.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  high only in IDLE.
- in_sum  input  MANT_W+1  adder result; bit MANT_W is carry-out.
- in_exp  input  EXP_W  tentative (larger operand) exponent.
- in_sign  input  1  result sign.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  downstream accept.
- out_mant  output  MANT_W  normalized mantissa.
- out_exp  output  EXP_W  adjusted exponent.
- out_sign  output  1  result sign.
- out_zero  output  1  result is exact zero.
- out_ovf  output  1  exponent overflow.
- out_unf  output  1  exponent underflow (denormal result).

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_mant/out_exp/out_sign/flags/out_valid = 0; in_ready=1 (in IDLE). Reset mid-SHIFT or mid-DONE discards the operation, no output produced.
- FSM states: IDLE, SHIFT, DONE. Internal mant/exp registers drive out_* directly; they are stable whenever out_valid=1.
- IDLE, accept on in_valid & in_ready (edge t0). Flags cleared, sign captured, then the first matching case applies:
  - in_sum==0: mant=0, exp=0, sign=0, out_zero=1 -> DONE.
  - carry (in_sum[MANT_W]=1): mant=in_sum[MANT_W:1] (LSB truncated), exp=in_exp+1. If in_exp >= 2^EXP_W-2: exp=all-ones, mant=0, out_ovf=1 -> DONE.
  - in_sum[MANT_W-1]=1: mant=in_sum[MANT_W-1:0], exp=in_exp -> DONE.
  - in_exp<=1: mant=in_sum[MANT_W-1:0], exp=0, out_unf=1 -> DONE.
  - otherwise: mant=in_sum[MANT_W-1:0], exp=in_exp -> SHIFT.
- SHIFT, evaluated each edge:
  - If exp==1: exp<=0, out_unf<=1, mant unchanged -> DONE.
  - Else: mant<=mant<<1, exp<=exp-1. If the shifted MSB is 1 -> DONE, else stay in SHIFT.
- DONE: out_valid=1. Hold all outputs until out_valid & out_ready, then -> IDLE; in_ready rises the following cycle. No new acceptance in the same cycle as output handshake.
- Latency (edges from acceptance edge t0 through the edge entering DONE, inclusive):
  - Fast paths: 1.
  - k left shifts: 1+k.
  - Underflow after j shifts: 2+j.
- Maximum latency is MANT_W edges. Throughput: one result per (latency+1) cycles minimum.
- No rounding: truncation only. The exponent never wraps; overflow saturates to all-ones and underflow floors at 0.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE (upstream must hold data until in_ready).

Test Plan:
1. Carry path: in_sum=17'h1_0005, in_exp=20, sign=0 -> out_mant=16'h8002, out_exp=21, flags 0, out_valid after edge 1.
2. Already normalized: in_sum=17'h0_8000, in_exp=10 -> out_mant=16'h8000, out_exp=10, latency 1. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
3. Max left shift: in_sum=17'h0_0001, in_exp=30 -> out_mant=16'h8000, out_exp=15, out_valid after edge 16.
4. Zero and overflow:
   - in_sum=0, in_exp=7, sign=1 -> out_zero=1, mant=0, exp=0, sign=0.
   - in_sum=17'h1_FFFF, in_exp=254 -> out_ovf=1, out_exp=255, out_mant=0.
5. Underflow: in_sum=17'h0_0100, in_exp=3 -> out_mant=16'h0400, out_exp=0, out_unf=1, out_valid after edge 4.
6. Reset mid-SHIFT: start case 3, assert rst_n=0 at edge 5 -> all outputs 0 immediately, in_ready=1. After release, case 1 completes correctly.

Source files
------------

// File: rtl/fp_add_normalizer.sv
// Post-adder normalization stage: takes the carry+mantissa sum from the add/sub
// stage and produces a normalized mantissa, adjusted exponent and status flags.
module fp_add_normalizer #(
  parameter int MANT_W = 16,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side data is held stable until that edge.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ALL1   = '1;
  localparam logic [EXP_W-1:0] EXP_OVF_TH = EXP_ALL1 - EXP_ONE;

  state_t              r_state, w_state_nxt;
  logic [MANT_W-1:0]   r_mant, w_mant_nxt;
  logic [EXP_W-1:0]    r_exp, w_exp_nxt;
  logic                r_sign, w_sign_nxt;
  logic                r_zero, w_zero_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic                r_unf, w_unf_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mant  <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mant  <= w_mant_nxt;
      r_exp   <= w_exp_nxt;
      r_sign  <= w_sign_nxt;
      r_zero  <= w_zero_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mant_nxt  = r_mant;
    w_exp_nxt   = r_exp;
    w_sign_nxt  = r_sign;
    w_zero_nxt  = r_zero;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_zero_nxt = 1'b0;
          w_ovf_nxt  = 1'b0;
          w_unf_nxt  = 1'b0;
          w_sign_nxt = in_sign;
          if (in_sum == '0) begin
            w_mant_nxt  = '0;
            w_exp_nxt   = '0;
            w_sign_nxt  = 1'b0;
            w_zero_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else if (in_sum[MANT_W]) begin
            // Carry-out: shift right by one, dropping the LSB.
            if (in_exp >= EXP_OVF_TH) begin
              w_mant_nxt = '0;
              w_exp_nxt  = EXP_ALL1;
              w_ovf_nxt  = 1'b1;
            end else begin
              w_mant_nxt = in_sum[MANT_W:1];
              w_exp_nxt  = in_exp + EXP_ONE;
            end
            w_state_nxt = S_DONE;
          end else if (in_sum[MANT_W-1]) begin
            w_mant_nxt  = in_sum[MANT_W-1:0];
            w_exp_nxt   = in_exp;
            w_state_nxt = S_DONE;
          end else if (in_exp <= EXP_ONE) begin
            w_mant_nxt  = in_sum[MANT_W-1:0];
            w_exp_nxt   = '0;
            w_unf_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_mant_nxt  = in_sum[MANT_W-1:0];
            w_exp_nxt   = in_exp;
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // Exponent 1 is the floor: stop shifting and report a denormal.
        if (r_exp == EXP_ONE) begin
          w_exp_nxt   = '0;
          w_unf_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_mant_nxt = {r_mant[MANT_W-2:0], 1'b0};
          w_exp_nxt  = r_exp - EXP_ONE;
          if (r_mant[MANT_W-2]) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_mant  = r_mant;
  assign out_exp   = r_exp;
  assign out_sign  = r_sign;
  assign out_zero  = r_zero;
  assign out_ovf   = r_ovf;
  assign out_unf   = r_unf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Bench for fp_add_normalizer: directed cases with literal expectations, then
// randomized traffic scored against a closed-form normalization model.
module tb_fp_add_normalizer;

  typedef struct packed {
    logic [7:0]  lat;
    logic        zero;
    logic        ovf;
    logic        unf;
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] mant;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_sum = '0;
  logic [7:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign, out_zero, out_ovf, out_unf;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            seen = 1'b0;
  bit            rand_mode = 1'b0;
  exp_t          ev;

  fp_add_normalizer #(.MANT_W(16), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Closed form: locate the leading one, then the shift count is clipped by
  // how far the exponent can drop before reaching the denormal floor.
  function automatic logic [EW-1:0] model(input logic [16:0] s, input logic [7:0] e, input logic sg);
    exp_t r;
    int p, k, j;
    logic [15:0] m;
    r = '0;
    r.sign = sg;
    r.lat = 8'd1;
    m = s[15:0];
    if (s == 17'd0) begin
      r.zero = 1'b1;
      r.sign = 1'b0;
    end else if (s[16]) begin
      if (e >= 8'd254) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
      end else begin
        r.mant = s[16:1];
        r.exp = e + 8'd1;
      end
    end else begin
      p = 15;
      while (p > 0 && !s[p]) p--;
      k = 15 - p;
      if (k == 0) begin
        r.mant = m;
        r.exp = e;
      end else if (e <= 8'd1) begin
        r.mant = m;
        r.unf = 1'b1;
      end else if (k <= int'(e) - 1) begin
        r.mant = m << k;
        r.exp = 8'(int'(e) - k);
        r.lat = 8'(1 + k);
      end else begin
        j = int'(e) - 1;
        r.mant = m << j;
        r.unf = 1'b1;
        r.lat = 8'(2 + j);
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [16:0] s, input logic [7:0] e, input logic sg);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid = 1'b1;
    in_sum = s;
    in_exp = e;
    in_sign = sg;
    exp_q.push_back(model(s, e, sg));
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    in_sum = 17'($urandom);
    in_exp = 8'($urandom);
    in_sign = 1'($urandom);
  endtask

  // Waits for out_valid with out_ready held low, checks literals, optionally
  // holds the result, then accepts it.
  task automatic expect_lit(input string name, input logic [15:0] m, input logic [7:0] e,
                            input logic sg, input logic z, input logic o, input logic u,
                            input int lat, input int hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({name, "_lat"}, 64'(n), 64'(lat));
    chk({name, "_out"}, {out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf},
        {m, e, sg, z, o, u});
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk({name, "_hold"}, {out_valid, in_ready, out_mant, out_exp}, {1'b1, 1'b0, m, e});
    end
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        ev = exp_q[0];
        chk("model_out", {out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf},
            {ev.mant, ev.exp, ev.sign, ev.zero, ev.ovf, ev.unf});
        if (!seen) begin
          seen = 1'b1;
          chk("model_latency", 64'(cyc - acc_q[0]), 64'(int'(ev.lat) - 1));
        end
        chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (acc_q.size() > 0) void'(acc_q.pop_front());
      seen = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [16:0] s;
    logic [7:0]  e;
    int          t;
    exp_t        pin;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf},
        '0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;

    // model pins
    pin = model(17'h0_0001, 8'd30, 1'b0);
    chk("pin_model_maxshift", pin, {8'd16, 4'b0000, 8'd15, 16'h8000});
    pin = model(17'h0_0100, 8'd3, 1'b0);
    chk("pin_model_unf", pin, {8'd4, 4'b0010, 8'd0, 16'h0400});

    send(17'h1_0005, 8'd20, 1'b0);
    expect_lit("carry", 16'h8002, 8'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    send(17'h0_8000, 8'd10, 1'b1);
    expect_lit("normed", 16'h8000, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5);
    send(17'h0_0001, 8'd30, 1'b0);
    expect_lit("maxshift", 16'h8000, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16, 0);
    send(17'h0_0000, 8'd7, 1'b1);
    expect_lit("zero", 16'h0000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
    send(17'h1_FFFF, 8'd254, 1'b0);
    expect_lit("ovf", 16'h0000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    send(17'h0_0100, 8'd3, 1'b0);
    expect_lit("unf", 16'h0400, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0);

    // reset in the middle of a long shift sequence
    send(17'h0_0001, 8'd30, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    seen = 1'b0;
    #1;
    chk("midshift_reset_outputs",
        {out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf}, '0);
    chk("midshift_reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;
    send(17'h1_0005, 8'd20, 1'b0);
    expect_lit("after_reset", 16'h8002, 8'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

    // randomized traffic with random downstream backpressure
    rand_mode = 1'b1;
    fork
      while (rand_mode) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: s = 17'($urandom_range(0, 17'h1FFFF));
        1: begin
          t = $urandom_range(0, 15);
          s = (17'd1 << t) | (17'($urandom) & ((17'd1 << t) - 17'd1));
        end
        2: s = 17'd0;
        3: s = {1'b1, 16'($urandom)};
        default: s = 17'd1 << $urandom_range(0, 16);
      endcase
      case ($urandom_range(0, 3))
        0: e = 8'($urandom_range(0, 4));
        1: e = 8'($urandom_range(250, 255));
        default: e = 8'($urandom_range(0, 255));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(s, e, 1'($urandom));
    end
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
